// File: rtl/ppx_freq_scheduler_if.sv
// Frequency-word stream carrying the next words to be applied on ppx edges.
//   tdata  : frequency word
//   tvalid : tdata holds a word
//   tready : the scheduler can accept a word this cycle
// master = word producer, slave = ppx_freq_scheduler.
interface ppx_freq_scheduler_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ppx_freq_scheduler.sv
// Queues frequency words and applies the next one on each enabled rising edge
// of a ppx pulse; flags and counts edges that find the queue empty.
//   clk, reset       : clock, synchronous active-high reset
//   en               : allow ppx edges to be consumed
//   ppx              : pulse/level from the ppx generator, any duty cycle
//   clear            : synchronous flush of the queue and the underflow flags
//   s                : word stream in (tdata/tvalid/tready)
//   freq_out         : currently applied frequency word
//   freq_strobe      : one-cycle pulse after freq_out is updated
//   underflow        : sticky, an enabled edge found the queue empty
//   fill             : queue occupancy, 0..2**DEPTH_LOG2
//   underflow_count  : saturating count of underflow events
module ppx_freq_scheduler #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH_LOG2 = 3,
    parameter logic [WIDTH-1:0] INIT_FREQ  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  ppx,
    input  logic                  clear,
    ppx_freq_scheduler_if.slave   s,
    output logic [WIDTH-1:0]      freq_out,
    output logic                  freq_strobe,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   fill,
    output logic [15:0]           underflow_count
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W  = DEPTH_LOG2;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             ppx_r;
    logic             ppx_d;
    logic             ppx_edge;
    logic             fire;
    logic             push;
    logic             pop;
    logic             miss;

    // Ready only with room, and never while reset or clear is asserted.
    assign s.tready = (fill < FILL_W'(DEPTH)) && !reset && !clear;

    // Edge qualification; a push into an empty queue is never bypassed to the output.
    always_comb begin
        ppx_edge = 1'b0;
        fire     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        miss     = 1'b0;
        ppx_edge = ppx_r & ~ppx_d;
        fire     = ppx_edge & en & ~clear;
        push     = s.tvalid & s.tready;
        pop      = fire & (fill != '0);
        miss     = fire & (fill == '0);
    end

    // Input sample register; keeps tracking ppx through reset so a level that is
    // already high at reset release is seen as an edge in the first cycle.
    always_ff @(posedge clk) begin
        ppx_r <= ppx;
    end

    // Word storage; push is already suppressed by reset and clear through tready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s.tdata;
        end
    end

    // Queue pointers, occupancy, applied word and underflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ppx_d           <= 1'b0;
            freq_out        <= INIT_FREQ;
            freq_strobe     <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
            fill            <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
        end else begin
            ppx_d       <= ppx_r;
            freq_strobe <= pop;
            if (clear) begin
                underflow       <= 1'b0;
                underflow_count <= '0;
                fill            <= '0;
                wr_ptr          <= '0;
                rd_ptr          <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    freq_out <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   fill <= fill + FILL_W'(1);
                    2'b01:   fill <= fill - FILL_W'(1);
                    default: fill <= fill;
                endcase
                if (miss) begin
                    underflow <= 1'b1;
                    if (underflow_count != CNT_MAX) begin
                        underflow_count <= underflow_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppx_freq_scheduler.sv
// Self-checking bench for ppx_freq_scheduler: a cycle table for the basic
// pop/underflow/clear flow, hand sequences for enable, full, clear and reset
// corners, and a scoreboard that checks every strobed word.
module tb_ppx_freq_scheduler;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DL2   = 3;
    localparam logic [31:0] INIT  = 32'h0000_0ABC;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic        ppx   = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] freq_out;
    logic        freq_strobe;
    logic        underflow;
    logic [3:0]  fill;
    logic [15:0] underflow_count;

    ppx_freq_scheduler_if #(.WIDTH(WIDTH)) s_if ();

    ppx_freq_scheduler #(
        .WIDTH(WIDTH),
        .DEPTH_LOG2(DL2),
        .INIT_FREQ(INIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .ppx(ppx),
        .clear(clear),
        .s(s_if),
        .freq_out(freq_out),
        .freq_strobe(freq_strobe),
        .underflow(underflow),
        .fill(fill),
        .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobe = 0;
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic tv, input logic [31:0] d, input logic p,
                       input logic e, input logic c);
        s_if.tvalid = tv;
        s_if.tdata  = d;
        ppx         = p;
        en          = e;
        clear       = c;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe must carry the oldest outstanding pushed word.
    always @(posedge clk) begin
        logic [31:0] exp_w;
        #1;
        if (freq_strobe) begin
            n_strobe++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_strobe: got freq_out 0x%0h expected no strobe", freq_out);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_freq", freq_out, exp_w);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        tv;
        logic [31:0] d;
        logic        p;
        logic        c;
        logic        acc;
        logic [3:0]  fill;
        logic        strobe;
        logic        uf;
        logic [15:0] cnt;
        logic [31:0] freq;
    } vec_t;

    vec_t tbl[26];

    initial begin
        // tv  data        ppx clr acc fill stb uf cnt freq
        tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, INIT};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd1, INIT};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd1, INIT};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd1, INIT};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd2, INIT};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd2, INIT};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, INIT};
        tbl[7]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 16'd0, INIT};
        tbl[8]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 16'd0, INIT};
        tbl[9]  = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 16'd0, INIT};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'd0, INIT};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'd0, 32'h100};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'd0, 32'h100};
        tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'd0, 32'h100};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'd0, 32'h100};
        tbl[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'd0, 32'h100};
        tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'd0, 32'h100};
        tbl[17] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 16'd0, 32'h200};
        tbl[18] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'd0, 32'h200};
        tbl[19] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'd0, 32'h200};
        tbl[20] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'd0, 32'h200};
        tbl[21] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'd0, 32'h200};
        tbl[22] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0, 32'h300};
        tbl[23] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 32'h300};
        tbl[24] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 32'h300};
        tbl[25] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 32'h300};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq_out", freq_out, INIT);
        chk("rst_strobe", 32'(freq_strobe), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_count", 32'(underflow_count), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_tready", 32'(s_if.tready), 32'd1);

        // Underflow, clear, three pushes and three 4-cycle pulses
        for (int i = 0; i < 26; i++) begin
            if (tbl[i].acc) sb.push_back(tbl[i].d);
            cyc(tbl[i].tv, tbl[i].d, tbl[i].p, 1'b1, tbl[i].c);
            if (tbl[i].c) sb.delete();
            chk($sformatf("tbl%0d_fill", i), 32'(fill), 32'(tbl[i].fill));
            chk($sformatf("tbl%0d_strobe", i), 32'(freq_strobe), 32'(tbl[i].strobe));
            chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].uf));
            chk($sformatf("tbl%0d_count", i), 32'(underflow_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_freq", i), freq_out, tbl[i].freq);
        end

        // Edges with en=0 are ignored
        cyc(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        begin
            int s0;
            s0 = n_strobe;
            for (int i = 0; i < 5; i++) begin
                cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
                cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            end
            chk("en0_fill", 32'(fill), 32'd2);
            chk("en0_underflow", 32'(underflow), 32'd0);
            chk("en0_strobes", 32'(n_strobe), 32'(s0));
            chk("en0_freq", freq_out, 32'h300);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("clr1_fill", 32'(fill), 32'd0);

        // Push into empty queue coincident with an edge: underflow, word stored
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        sb.push_back(32'h55);
        cyc(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
        chk("coinc_fill", 32'(fill), 32'd1);
        chk("coinc_underflow", 32'(underflow), 32'd1);
        chk("coinc_count", 32'(underflow_count), 32'd1);
        chk("coinc_strobe", 32'(freq_strobe), 32'd0);
        chk("coinc_freq", freq_out, 32'h300);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("coinc_pop_strobe", 32'(freq_strobe), 32'd1);
        chk("coinc_pop_freq", freq_out, 32'h55);
        chk("coinc_pop_fill", 32'(fill), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Clear with fill=3 after underflow, coincident edge and push suppressed
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h60 + 32'(i), 1'b0, 1'b1, 1'b0);
        chk("pre_clr_fill", 32'(fill), 32'd3);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h77;
        ppx         = 1'b1;
        clear       = 1'b1;
        #1;
        chk("clr_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk);
        #1;
        chk("clr_fill", 32'(fill), 32'd0);
        chk("clr_underflow", 32'(underflow), 32'd0);
        chk("clr_count", 32'(underflow_count), 32'd0);
        chk("clr_strobe", 32'(freq_strobe), 32'd0);
        chk("clr_freq", freq_out, 32'h55);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("post_clr_strobe", 32'(freq_strobe), 32'd0);
        chk("post_clr_fill", 32'(fill), 32'd0);

        // Fill to 8, ninth word waits; edge while full frees a slot a cycle later
        for (int i = 0; i < 8; i++) begin
            sb.push_back(32'h1000 + 32'(i));
            cyc(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b1, 1'b0);
        end
        chk("full_fill", 32'(fill), 32'd8);
        chk("full_tready", 32'(s_if.tready), 32'd0);
        cyc(1'b1, 32'h1008, 1'b0, 1'b1, 1'b0);
        chk("full_reject_fill", 32'(fill), 32'd8);
        cyc(1'b1, 32'h1008, 1'b1, 1'b1, 1'b0);
        chk("full_pre_edge_fill", 32'(fill), 32'd8);
        chk("full_edge_tready", 32'(s_if.tready), 32'd0);
        cyc(1'b1, 32'h1008, 1'b1, 1'b1, 1'b0);
        chk("full_pop_fill", 32'(fill), 32'd7);
        chk("full_pop_strobe", 32'(freq_strobe), 32'd1);
        sb.push_back(32'h1008);
        cyc(1'b1, 32'h1008, 1'b1, 1'b1, 1'b0);
        chk("ninth_fill", 32'(fill), 32'd8);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        chk("drain_fill", 32'(fill), 32'd5);
        chk("drain_freq", freq_out, 32'h1003);

        // Reset mid-stream with fill=5 and ppx high
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        sb.delete();
        chk("mid_rst_freq", freq_out, INIT);
        chk("mid_rst_strobe", 32'(freq_strobe), 32'd0);
        chk("mid_rst_underflow", 32'(underflow), 32'd0);
        chk("mid_rst_count", 32'(underflow_count), 32'd0);
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_tready", 32'(s_if.tready), 32'd0);
        reset = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("rel_edge_underflow", 32'(underflow), 32'd1);
        chk("rel_edge_count", 32'(underflow_count), 32'd1);
        chk("rel_edge_fill", 32'(fill), 32'd0);
        chk("rel_edge_strobe", 32'(freq_strobe), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        chk("total_strobes", 32'(n_strobe), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
